// File: rtl/snoopy_game_sequencer.sv
// Snoopy side-scroller sequencer: game FSM, move pacing, button arbitration, scoring.
// Optional macro SCORE_HEX_EN adds the registered HEX0_o score digit.
module snoopy_game_sequencer #(
  parameter int MOVE_DIV = 250000,
  parameter int MAX_X    = 155,
  parameter int NUM_OBST = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_start_i,
  input  logic [7:0] snoopy_x_i,
  input  logic       collision_i,
  output logic       move_tick_o,
  output logic       move_left_o,
  output logic       move_right_o,
  output logic [1:0] game_state_o,
  output logic [3:0] score_o
`ifdef SCORE_HEX_EN
  ,
  output logic [6:0] HEX0_o
`endif
);

  typedef enum logic [1:0] {S_WAIT = 2'b00, S_PLAY = 2'b01, S_WIN = 2'b10, S_DEAD = 2'b11} state_t;

  localparam int              CW        = $clog2(MOVE_DIV);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(MOVE_DIV - 1);
  localparam logic [3:0]      SCORE_MAX = 4'(NUM_OBST);
  localparam logic [7:0]      X_MAX     = 8'(MAX_X);

  // Obstacle-clearing x thresholds, indexed by the current score.
  function automatic logic [7:0] thresh(input logic [3:0] s);
    case (s)
      4'd0:    thresh = 8'd40;
      4'd1:    thresh = 8'd61;
      4'd2:    thresh = 8'd81;
      4'd3:    thresh = 8'd111;
      4'd4:    thresh = 8'd127;
      4'd5:    thresh = 8'd154;
      default: thresh = 8'hFF;
    endcase
  endfunction

  state_t        state_q;
  logic [3:0]    score_q;
  logic [CW-1:0] cnt_q;
  logic          tick_q, left_q, right_q;
  logic          start_p_q, left_p_q, right_p_q;
  logic          last_right_q, last_right_d;
  logic          start_rise, left_rise, right_rise;
  logic          go_left_d, go_right_d;

  assign start_rise = btn_start_i & ~start_p_q;
  assign left_rise  = btn_left_i  & ~left_p_q;
  assign right_rise = btn_right_i & ~right_p_q;

  // Most recent rise wins when both are held; a simultaneous rise favours left.
  always_comb begin
    last_right_d = last_right_q;
    if (left_rise)       last_right_d = 1'b0;
    else if (right_rise) last_right_d = 1'b1;
  end

  assign go_left_d  = btn_left_i  & (~btn_right_i | ~last_right_d);
  assign go_right_d = btn_right_i & (~btn_left_i  |  last_right_d);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_WAIT;
      score_q      <= '0;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      start_p_q    <= 1'b0;
      left_p_q     <= 1'b0;
      right_p_q    <= 1'b0;
      last_right_q <= 1'b0;
    end else begin
      start_p_q    <= btn_start_i;
      left_p_q     <= btn_left_i;
      right_p_q    <= btn_right_i;
      last_right_q <= last_right_d;
      tick_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      cnt_q        <= '0;
      case (state_q)
        S_WAIT: begin
          score_q <= '0;
          if (start_rise) state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (score_q < SCORE_MAX && snoopy_x_i >= thresh(score_q))
            score_q <= score_q + 4'd1;
          if (collision_i)
            state_q <= S_DEAD;
          else if (score_q == SCORE_MAX)
            state_q <= S_WIN;
          else begin
            // Pacing only continues while staying in PLAY, so leaving drops the pulse.
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              tick_q  <= 1'b1;
              left_q  <= go_left_d  && (snoopy_x_i != 8'd0);
              right_q <= go_right_d && (snoopy_x_i < X_MAX);
            end
          end
        end
        default: begin
          if (start_rise) begin
            state_q <= S_WAIT;
            score_q <= '0;
          end
        end
      endcase
    end
  end

  assign move_tick_o  = tick_q;
  assign move_left_o  = left_q;
  assign move_right_o = right_q;
  assign game_state_o = state_q;
  assign score_o      = score_q;

`ifdef SCORE_HEX_EN
  logic [6:0] hex_q;

  // Active-low gfedcba segments; follows score one cycle later.
  always_ff @(posedge clock) begin
    if (!reset) hex_q <= 7'b1000000;
    else begin
      case (score_q)
        4'h0: hex_q <= 7'b1000000;
        4'h1: hex_q <= 7'b1111001;
        4'h2: hex_q <= 7'b0100100;
        4'h3: hex_q <= 7'b0110000;
        4'h4: hex_q <= 7'b0011001;
        4'h5: hex_q <= 7'b0010010;
        4'h6: hex_q <= 7'b0000010;
        4'h7: hex_q <= 7'b1111000;
        4'h8: hex_q <= 7'b0000000;
        4'h9: hex_q <= 7'b0010000;
        4'hA: hex_q <= 7'b0001000;
        4'hB: hex_q <= 7'b0000011;
        4'hC: hex_q <= 7'b1000110;
        4'hD: hex_q <= 7'b0100001;
        4'hE: hex_q <= 7'b0000110;
        default: hex_q <= 7'b0001110;
      endcase
    end
  end

  assign HEX0_o = hex_q;
`endif

endmodule

// File: tb/tb_snoopy_game_sequencer.sv
// Bench for snoopy_game_sequencer: per-cycle behavioural model plus directed literal checks.
module tb_snoopy_game_sequencer;
  localparam int MOVE_DIV = 4;
  localparam int MAX_X    = 155;
  localparam int NUM_OBST = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       bl = 1'b0, br = 1'b0, bs = 1'b0, coll = 1'b0;
  logic [7:0] x = 8'd0;
  logic       mt, ml, mr;
  logic [1:0] gs;
  logic [3:0] sc;
`ifdef SCORE_HEX_EN
  logic [6:0] hex;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  snoopy_game_sequencer #(.MOVE_DIV(MOVE_DIV), .MAX_X(MAX_X), .NUM_OBST(NUM_OBST)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_left_i  (bl),
    .btn_right_i (br),
    .btn_start_i (bs),
    .snoopy_x_i  (x),
    .collision_i (coll),
    .move_tick_o (mt),
    .move_left_o (ml),
    .move_right_o(mr),
    .game_state_o(gs),
    .score_o     (sc)
`ifdef SCORE_HEX_EN
    ,
    .HEX0_o      (hex)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: game described by play age, press timestamps and threshold table.
  int thr[6] = '{40, 61, 81, 111, 127, 154};
  int m_state = 0, m_score = 0, m_age = 0, m_tick = 0, m_ml = 0, m_mr = 0;
  int pS = 0, pL = 0, pR = 0, tL = 0, tR = 0, cyc = 1;

  always @(posedge clock) begin
    int ns, nsc, dir;
    if (!reset) begin
      m_state = 0; m_score = 0; m_age = 0; m_tick = 0; m_ml = 0; m_mr = 0;
      pS = 0; pL = 0; pR = 0; tL = 0; tR = 0;
    end else begin
      if (bl && pL == 0) tL = cyc;
      if (br && pR == 0) tR = cyc;
      ns = m_state;
      nsc = m_score;
      case (m_state)
        0: if (bs && pS == 0) ns = 1;
        1: begin
          if (m_score < NUM_OBST && int'(x) >= thr[m_score]) nsc = m_score + 1;
          if (coll) ns = 3;
          else if (m_score == NUM_OBST) ns = 2;
        end
        default: if (bs && pS == 0) begin ns = 0; nsc = 0; end
      endcase
      m_age  = (m_state == 1 && ns == 1) ? m_age + 1 : 0;
      m_tick = (ns == 1 && m_age > 0 && m_age % MOVE_DIV == 0) ? 1 : 0;
      if (bl && !br)      dir = 1;
      else if (br && !bl) dir = 2;
      else if (bl && br)  dir = (tL >= tR) ? 1 : 2;
      else                dir = 0;
      m_ml = (m_tick == 1 && dir == 1 && x != 8'd0) ? 1 : 0;
      m_mr = (m_tick == 1 && dir == 2 && int'(x) < MAX_X) ? 1 : 0;
      m_state = ns;
      m_score = nsc;
      pS = int'(bs); pL = int'(bl); pR = int'(br);
    end
    cyc++;
    #1;
    check("m_state", gs, m_state);
    check("m_score", sc, m_score);
    check("m_tick", mt, m_tick);
    check("m_left", ml, m_ml);
    check("m_right", mr, m_mr);
  end

  task automatic window(input int n, output int t, output int l, output int r);
    t = 0; l = 0; r = 0;
    repeat (n) begin
      @(negedge clock);
      t += int'(mt); l += int'(ml); r += int'(mr);
    end
  endtask

  task automatic start_pulse();
    bs = 1'b1;
    @(negedge clock);
    bs = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int t, l, r;
    repeat (3) @(negedge clock);
    check("rst_state", gs, 0);
    check("rst_score", sc, 0);
    check("rst_outs", {mt, ml, mr}, 0);
`ifdef SCORE_HEX_EN
    check("rst_hex", hex, 7'b1000000);
`endif
    reset = 1'b1;
    @(negedge clock);
    bs = 1'b1;
    @(negedge clock);
    check("start_to_play", gs, 1);
    bs = 1'b0;
    window(16, t, l, r);
    check("tick_every_4", t, 4);
    check("idle_no_moves", l + r, 0);

    x = 8'd20;
    bl = 1'b1;
    window(4, t, l, r);
    check("left_only_l", l, 1);
    check("left_only_r", r, 0);
    br = 1'b1;
    window(4, t, l, r);
    check("right_newer_r", r, 1);
    check("right_newer_l", l, 0);
    br = 1'b0;
    window(4, t, l, r);
    check("right_released_l", l, 1);
    check("right_released_r", r, 0);
    bl = 1'b0;
    @(negedge clock);
    bl = 1'b1; br = 1'b1;
    window(4, t, l, r);
    check("same_rise_l", l, 1);
    check("same_rise_r", r, 0);
    bl = 1'b0;
    window(12, t, l, r);
    check("right_held_r", r, 3);
    check("right_held_l", l, 0);
    br = 1'b0; bl = 1'b1; x = 8'd0;
    window(4, t, l, r);
    check("left_bound_tick", t, 1);
    check("left_bound_l", l, 0);
    bl = 1'b0; br = 1'b1; x = 8'd155;
    window(4, t, l, r);
    check("right_bound_tick", t, 1);
    check("right_bound_r", r, 0);
    check("fast_score", sc, 4);
    window(3, t, l, r);
    check("win_state", gs, 2);
    check("win_score", sc, 6);
    br = 1'b0; x = 8'd30;
    window(3, t, l, r);
    check("win_frozen", sc, 6);
    bs = 1'b1;
    @(negedge clock);
    check("win_to_wait", gs, 0);
    check("wait_clears", sc, 0);
    bs = 1'b0;
    @(negedge clock);

    start_pulse();
    for (int xi = 0; xi <= 160; xi++) begin
      x = 8'(xi);
      @(negedge clock);
      for (int i = 0; i < 6; i++) begin
        if (xi == thr[i])     check("sweep_step", sc, i + 1);
        if (xi == thr[i] - 1) check("sweep_below", sc, i);
      end
      if (xi == 155) check("sweep_win", gs, 2);
`ifdef SCORE_HEX_EN
      if (xi == 100) check("hex_three", hex, 7'b0110000);
`endif
    end
    x = 8'd30;
    window(2, t, l, r);
    check("sweep_x_back", sc, 6);

    start_pulse();
    start_pulse();
    x = 8'd150;
    window(5, t, l, r);
    check("coll_pre_score", sc, 5);
    x = 8'd154;
    @(negedge clock);
    check("coll_score6", sc, 6);
    check("coll_still_play", gs, 1);
    coll = 1'b1;
    @(negedge clock);
    check("coll_beats_win", gs, 3);
    coll = 1'b0; x = 8'd30;
    window(3, t, l, r);
    check("dead_frozen", sc, 6);
    bs = 1'b1;
    @(negedge clock);
    check("dead_to_wait", gs, 0);
    check("dead_clears", sc, 0);
    bs = 1'b0;
    @(negedge clock);

    start_pulse();
    bl = 1'b1; x = 8'd50;
    window(6, t, l, r);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_state", gs, 0);
    check("midrst_score", sc, 0);
    check("midrst_outs", {mt, ml, mr}, 0);
    reset = 1'b1; bl = 1'b0;
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snoopy_game_sequencer.md
Name: snoopy_game_sequencer

Overview:
Top-level sequencer for the Snoopy side-scroller: runs the game state machine (wait/play/win/dead), paces horizontal motion with a programmable move tick, and arbitrates the left/right buttons into single-cycle step commands for the horizontal position datapath. It also scores obstacle crossings from the returned Snoopy x coordinate and ends the round on collision or full score. It sits between the board buttons and collision detector on one side and the horizontal position block and HEX display on the other.

Parameters:
MOVE_DIV, 250000, clock cycles between move ticks (>=2)
MAX_X, 155, rightmost legal snoopy_x
NUM_OBST, 6, obstacles per round; winning score

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low
btn_left  in  1  left request, level, pre-synchronised
btn_right  in  1  right request, level, pre-synchronised
btn_start  in  1  start/restart, level, pre-synchronised
snoopy_x  in  8  current Snoopy x from position datapath
collision  in  1  Snoopy overlaps obstacle, level
move_tick  out  1  one-cycle pacing pulse, PLAY only
move_left  out  1  one-cycle step-left command
move_right  out  1  one-cycle step-right command
game_state  out  2  00 WAIT, 01 PLAY, 10 WIN, 11 DEAD
score  out  4  obstacles cleared, 0..NUM_OBST
HEX0  out  7  seven-seg score digit, active-low (SCORE_HEX_EN only)

Behaviour:
- Reset (reset==0 at clock edge): game_state=WAIT, score=0, move_tick/move_left/move_right=0, tick counter=0, last-direction=left, button edge registers=0; HEX0 shows 0. Reset mid-round aborts immediately.
- Edge detect: registered copies of btn_start/left/right; "rise" = now 1, previous 0.
- FSM: WAIT -> PLAY on btn_start rise. PLAY -> DEAD on collision==1; PLAY -> WIN when score==NUM_OBST; collision beats win in the same cycle. WIN/DEAD -> WAIT on btn_start rise. WAIT entry clears score and tick counter.
- Tick counter: runs only in PLAY, 0..MOVE_DIV-1; move_tick=1 for the cycle after counter reaches MOVE_DIV-1 (registered), counter wraps to 0. Held at 0 outside PLAY; leaving PLAY suppresses any pending pulse.
- Direction arbitration: only left held -> left; only right held -> right; both held -> most recently risen wins; both rise same cycle -> left; neither -> none.
- move_left/move_right asserted only coincident with move_tick, mutually exclusive. Bounds: no move_left when snoopy_x==0; no move_right when snoopy_x>=MAX_X.
- Scoring, PLAY only: thresholds T[0..5]=40,61,81,111,127,154. If score<NUM_OBST and snoopy_x>=T[score], score increments by 1 next cycle (at most +1 per cycle; moving left never decrements). Saturates at NUM_OBST. Score frozen in WIN/DEAD.
- All outputs registered; no combinational input->output path.

Optional Feature:
SCORE_HEX_EN: when defined, HEX0 port exists and drives active-low segment pattern (gfedcba) for score 0..9 hex digit, registered, reset to "0" pattern 7'b1000000. When undefined, HEX0 port and decoder are absent; all other behaviour identical.

Test Plan:
- Reset then btn_start pulse, MOVE_DIV=4 -> game_state 00->01 one cycle after rise; move_tick every 4th cycle; score=0.
- PLAY, btn_right held, snoopy_x=20 -> move_right pulses only with move_tick, move_left=0; snoopy_x=155 -> move_right suppressed, move_tick continues.
- btn_left held, then btn_right rises while left still held -> next tick move_right; release right -> next tick move_left; both rising same cycle -> move_left.
- Sweep snoopy_x 0->160 in PLAY -> score steps 1..6 at x=40,61,81,111,127,154; state 10 (WIN) the cycle after score==6; x back to 30 leaves score 6.
- collision=1 in same cycle score reaches 6 -> state 11 (DEAD); btn_start rise -> WAIT with score 0; reset asserted mid-PLAY -> WAIT, all outputs 0.
- SCORE_HEX_EN defined, score=3 -> HEX0=7'b0110000; score=0 after reset -> 7'b1000000.
